// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned multiply/divide unit: shift-add multiply and restoring
// divide share one 2*WIDTH accumulator, one iteration per clock.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     opnd_q;
  logic [1:0]           op_q;
  logic [3:0]           rd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [WIDTH-1:0]     result_q;
  logic [3:0]           rd_out_q;

  // Multiply step: acc = {partial product, remaining multiplier bits}; add then shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // Divide step: acc = {partial remainder, dividend/quotient}; shift left, trial subtract.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, d};
    if (trial >= {1'b0, d}) begin
      return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    return {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    acc_d = op_q[1] ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            dbz_q    <= 1'b0;
            result_q <= op_q[0] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
            rd_out_q <= rd_q;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, giving back-to-back throughput.
          if (start) begin
            acc_q  <= {{WIDTH{1'b0}}, a};
            opnd_q <= b;
            op_q   <= op;
            rd_q   <= rd_in;
            cnt_q  <= '0;
            if (op[1] && (b == '0)) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              dbz_q    <= 1'b1;
              result_q <= op[0] ? a : {WIDTH{1'b1}};
              rd_out_q <= rd_in;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wr          = done_q;
  assign result      = result_q;
  assign rd_out      = rd_out_q;
  assign div_by_zero = dbz_q;

endmodule
